mem_bus_if: RTL

//  Parametrised MAR/MDR memory interface for the bus-based datapath; successor to the fixed 32-bit MAR/MDR pair.

---
 rtl/mem_bus_if.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_bus_if.sv
// MAR/MDR memory interface: latches address/data from the datapath bus and runs
// a req/ack handshake with variable-latency memory, with bounded timeout and sticky error.
module mem_bus_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              mar_in,
   input  logic              mdr_in,
   input  logic              rd_req,
   input  logic              wr_req,
   output logic [DATA_W-1:0] mdr_out,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  mar, mar_nxt;
   logic [DATA_W-1:0]  mdr, mdr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               req_nxt, we_nxt, busy_nxt, done_nxt, err_nxt;

   assign mem_addr  = mar;
   assign mem_wdata = mdr;
   assign mdr_out   = mdr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         mar     <= '0;
         mdr     <= '0;
         cnt     <= '0;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         mar     <= mar_nxt;
         mdr     <= mdr_nxt;
         cnt     <= cnt_nxt;
         mem_req <= req_nxt;
         mem_we  <= we_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
      end
   end

   // Next state and next registered outputs; every output flop is computed here.
   always_comb begin
      state_nxt = state;
      mar_nxt   = mar;
      mdr_nxt   = mdr;
      cnt_nxt   = cnt;
      req_nxt   = mem_req;
      we_nxt    = mem_we;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      err_nxt   = err;

      case (state)
         IDLE: begin
            if (mar_in) mar_nxt = bus_in[ADDR_W-1:0];
            if (mdr_in) mdr_nxt = bus_in;
            if (rd_req || wr_req) begin
               state_nxt = REQ;
               req_nxt   = 1'b1;
               we_nxt    = wr_req;
               busy_nxt  = 1'b1;
               err_nxt   = 1'b0;
               cnt_nxt   = '0;
            end
         end
         REQ: begin
            // An ack in the timeout cycle still wins, so it is tested first.
            if (mem_ack) begin
               if (!mem_we) mdr_nxt = mem_rdata;
               state_nxt = DONE;
               req_nxt   = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + CNT_W'(1);
               if ((TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST))) begin
                  err_nxt   = 1'b1;
                  state_nxt = DONE;
                  req_nxt   = 1'b0;
                  done_nxt  = 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            we_nxt    = 1'b0;
            busy_nxt  = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule
